// File: rtl/axis_checksum_append.sv
// Byte-wide AXI-Stream pass-through that appends a two's-complement checksum
// byte after each packet (carrying tlast), counts packets and flags overlength.
module axis_checksum_append #(
   parameter int MAX_LEN = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_tvalid,
   input  logic [7:0]  s_tdata,
   input  logic        s_tlast,
   output logic        s_tready,
   output logic        m_tvalid,
   output logic [7:0]  m_tdata,
   output logic        m_tlast,
   input  logic        m_tready,
   output logic [15:0] pkt_count,
   output logic        len_err
);

   localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

   typedef enum logic {PASS, CSUM} state_t;

   state_t      state, state_nxt;
   logic        slot_free;
   logic        ld_byte;
   logic        ld_csum;
   logic [7:0]  sum;
   logic [15:0] byte_cnt;

   assign slot_free = !m_tvalid || m_tready;

   always_ff @(posedge clk) begin
      if (reset) state <= PASS;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         PASS:    if (ld_byte && s_tlast) state_nxt = CSUM;
         CSUM:    if (slot_free)          state_nxt = PASS;
         default: state_nxt = PASS;
      endcase
   end

   // The input is only open in PASS; CSUM owns the slot for the checksum byte.
   always_comb begin
      s_tready = 1'b0;
      ld_byte  = 1'b0;
      ld_csum  = 1'b0;
      unique case (state)
         PASS: begin
            s_tready = slot_free;
            ld_byte  = s_tvalid && slot_free;
         end
         CSUM:    ld_csum = slot_free;
         default: ;
      endcase
   end

   // sum carries the final payload sum into CSUM, so no separate latch is needed.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_tvalid <= 1'b0;
         m_tdata  <= 8'h00;
         m_tlast  <= 1'b0;
         sum      <= 8'h00;
         byte_cnt <= 16'h0000;
         len_err  <= 1'b0;
      end else if (ld_byte) begin
         m_tdata  <= s_tdata;
         m_tlast  <= 1'b0;
         m_tvalid <= 1'b1;
         sum      <= sum + s_tdata;
         byte_cnt <= s_tlast ? 16'h0000 : byte_cnt + 16'd1;
         if (byte_cnt == MAX_LEN_W) len_err <= 1'b1;
      end else if (ld_csum) begin
         m_tdata  <= ~sum + 8'd1;
         m_tlast  <= 1'b1;
         m_tvalid <= 1'b1;
         sum      <= 8'h00;
      end else if (slot_free) begin
         m_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                              pkt_count <= 16'h0000;
      else if (m_tvalid && m_tready && m_tlast) pkt_count <= pkt_count + 16'd1;
   end

endmodule

// File: doc/axis_checksum_append.md
# axis_checksum_append

Byte-wide AXI-Stream stage between the stream master and the stream slave. It forwards each packet unchanged through a one-deep registered output slot. After the packet's last byte it appends one two's-complement checksum byte and moves `tlast` onto that byte, so the sum of all delivered bytes in a packet is 0 mod 256. It also counts completed packets and flags packets longer than `MAX_LEN`.

## Interface
- `MAX_LEN`, default 64: maximum payload bytes per packet, excluding the checksum; range 1..65535.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `s_tvalid` input 1: upstream byte valid.
- `s_tdata` input 8: upstream byte.
- `s_tlast` input 1: last payload byte of the packet.
- `s_tready` output 1: block accepts the upstream byte this cycle.
- `m_tvalid` output 1: downstream byte valid (registered).
- `m_tdata` output 8: downstream byte (registered).
- `m_tlast` output 1: high only on the appended checksum byte (registered).
- `m_tready` input 1: downstream accepts the byte.
- `pkt_count` output 16: number of checksum bytes delivered; wraps 65535 -> 0.
- `len_err` output 1: sticky flag, set when any packet exceeds `MAX_LEN` payload bytes.

## Operation
- Internal state:
  - FSM state `PASS`/`CSUM`;
  - `sum[7:0]`, the running payload sum mod 256;
  - `byte_cnt[15:0]`, payload bytes accepted in the current packet.
- Output slot is free when `!m_tvalid || m_tready`.
- `PASS` state:
  - `s_tready` = slot free (combinational from `m_tready`).
  - On input handshake: `m_tdata <= s_tdata`, `m_tlast <= 0`, `m_tvalid <= 1`, `sum <= sum + s_tdata`, `byte_cnt <= byte_cnt + 1`.
  - If the accepted byte has `byte_cnt == MAX_LEN` (i.e. payload byte `MAX_LEN+1`): `len_err <= 1`. The byte is still forwarded; the packet is not truncated.
  - If `s_tlast` is also high: go to `CSUM`, latch the final sum, and clear `byte_cnt`.
  - Slot free with no input handshake: `m_tvalid <= 0`.
- `CSUM` state:
  - `s_tready = 0`.
  - When the slot is free: `m_tdata <= (~final_sum + 1)`, `m_tlast <= 1`, `m_tvalid <= 1`, `sum <= 0`, then go to `PASS`.
- `pkt_count` increments on each cycle where `m_tvalid && m_tready && m_tlast`.
- Checksum is 8-bit modular arithmetic. All carries are discarded. Final sum 0 gives checksum 0x00.
- Back-pressure: while `m_tvalid && !m_tready`, `m_tdata`, `m_tlast` and `m_tvalid` hold stable and `s_tready = 0`.
- `reset`: clears all registers:
  - `m_tvalid = 0`, `m_tdata = 0`, `m_tlast = 0`, `pkt_count = 0`, `len_err = 0`;
  - `sum = 0`, `byte_cnt = 0`, state `PASS`.
  - `s_tready` reads 1 in the cycle after reset deasserts.
- Reset mid-packet: the partial packet and any pending checksum are discarded, and no checksum is emitted. The next accepted byte starts a new packet.
- `s_tvalid` and `s_tdata` are ignored while `s_tready = 0`. Upstream holds its data per the AXI-Stream rules.

## Timing
- Latency: an accepted byte appears on `m_*` in the next cycle.
- The checksum is loaded into the slot on the same edge the last payload byte leaves the slot, or on the next edge if the slot is already free.
- Throughput with `m_tready` held at 1: one byte per cycle within a packet. There is one input bubble per packet, the cycle where `s_tready = 0` in `CSUM`.
  - An N-byte packet occupies N+1 output cycles.
  - Back-to-back packets: input accepts N bytes in N+1 cycles.
- Simultaneous slot drain and input handshake in `PASS`: the slot reloads with the new byte and `m_tvalid` stays 1 with no gap.
- `pkt_count` and `len_err` update one cycle after their triggering handshake or accept edge.

## Test plan
- **3-byte packet:** reset, then send 0x01, 0x02, 0x03 (`tlast` on 0x03) with `m_tready = 1`.
  - Output is 0x01, 0x02, 0x03, 0xFA with `m_tlast` only on 0xFA.
  - `pkt_count = 1`.
  - `s_tready` is low for exactly one cycle.
- **Single-byte packet:** send 0x80 with `tlast`. Output is 0x80, 0x80 (`tlast`). Then a packet of 0xFF, 0x01 gives checksum 0x00.
- **Back-pressure:** hold `m_tready = 0` for 5 cycles mid-packet.
  - `m_tdata`/`m_tvalid` stay stable and `s_tready = 0` throughout.
  - After release, the sequence completes with no loss or duplication.
- **Overlength:** with `MAX_LEN = 4`, send a 5-byte packet 1..5.
  - `len_err` rises one cycle after the 5th byte is accepted.
  - All 5 bytes are forwarded, plus checksum 0xF1.
  - `len_err` stays 1 through subsequent good packets.
- **Reset mid-packet:** assert `reset` after 2 of 4 bytes.
  - All outputs return to 0.
  - A following packet 0x10 (`tlast`) outputs 0x10, 0xF0, and `pkt_count = 1`.
- **Counter wrap:** stream 65536 one-byte packets. `pkt_count` reads 0 after the last checksum handshake.
